preemph: RTL and testbench
==========================

Name: preemph

Overview:
- Transmit-side counterpart of the FM receive chain's de-emphasis filter. Boosts high audio frequencies before modulation, for loopback and test-signal generation.
- Implements a quantized first-order section: y[n] = DEQUANTIZE(B0*x[n] + B1*x[n-1] + A1*y[n-1]).
- Uses one time-multiplexed multiplier. Sits between two FIFOs: it reads audio samples from the upstream FIFO and writes pre-emphasized samples to the downstream FIFO.

Parameters:
- DATA_WIDTH, 32, sample/accumulator width (two's complement)
- BITS, 10, quantization fraction bits (QUANT_VAL = 1<<BITS)
- B0, 32'sd1024, x[n] coefficient (1.0)
- B1, -32'sd668, x[n-1] coefficient (-0.652)
- A1, 32'sd0, y[n-1] feedback coefficient (added, same sign convention as de-emphasis Y tap)

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- in_rd_en  out  1  upstream FIFO read strobe
- in_empty  in  1  upstream FIFO empty
- in_dout  in  DATA_WIDTH  upstream FIFO data (first-word-fall-through: valid while in_empty=0)
- out_wr_en  out  1  downstream FIFO write strobe
- out_full  in  1  downstream FIFO full
- out_din  out  DATA_WIDTH  downstream FIFO data

Behaviour:
- Reset (reset=0, async): state=S_IDLE; x_cur, x1, y1, acc, y_reg = 0; in_rd_en=0; out_wr_en=0; out_din=0.
  - Reset asserted mid-computation discards the in-flight sample; history restarts at zero.
- FSM:
  - S_IDLE: if in_empty=0, assert in_rd_en for exactly this cycle, capture x_cur=in_dout, go to S_MUL0. Otherwise stay; in_rd_en=0.
  - S_MUL0: acc = B0*x_cur -> S_MUL1.
  - S_MUL1: acc += B1*x1 -> S_MUL2.
  - S_MUL2: y_reg = DEQUANTIZE(acc + A1*y1) -> S_WRITE.
  - S_WRITE: if out_full=0, out_wr_en=1 and out_din=y_reg (both combinational from state/out_full); update x1=x_cur, y1=y_reg; go to S_IDLE. If out_full=1, hold in S_WRITE with out_wr_en=0 and no history update.
- in_rd_en is never asserted outside S_IDLE, so at most one sample is in flight. This gives natural backpressure: upstream stalls while downstream is full.
- Timing:
  - Latency: sample read at cycle t is written at cycle t+4 at the earliest.
  - Throughput: 1 sample per 5 cycles with no stalls.
- Arithmetic:
  - Each product is the low DATA_WIDTH bits of a signed multiply; sums wrap two's complement. This is bit-exact with the chain's 32-bit int C model.
  - DEQUANTIZE(v): if v negative, (v + QUANT_VAL - 1) >>> BITS; else v >>> BITS (round toward zero).
- Simultaneous events:
  - out_full deasserting in the same cycle S_WRITE is entered: the write happens that cycle.
  - in_empty toggling during MUL states is ignored.
- out_din holds 0 except in cycles where out_wr_en=1.

Decomposition:
- Shared package preemph_pkg:
  - BITS, QUANT_VAL, DEQUANTIZE function.
  - Default coefficient constants (also reusable by the de-emphasis block for its quantized taps).
  - State enum {S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_WRITE}.
- One natural sub-module: iir_mac
  - Registered accumulator with a single signed multiplier.
  - Inputs: clear/accumulate select, operand A, operand B.
  - Reused by other single-multiplier filters in the chain.

Test Plan:
1. Defaults, zero history; push 1000 then 1000 -> out_din 1000 then 347; each out_wr_en exactly 4 cycles after its in_rd_en.
2. Defaults; push -1000 then -1000 -> outputs -1000 then -347 (round toward zero, not floor -348).
3. B0=1024, B1=0, A1=512; push 1000, 0, 0, 0 -> outputs 1000, 500, 250, 125.
4. out_full=1 held 10 cycles at S_WRITE:
   - out_wr_en stays 0; in_rd_en stays 0 even with in_empty=0.
   - On release, exactly one write of the held value, then reading resumes.
5. Assert reset for 1 cycle during S_MUL1 of the second sample -> no write for that sample; next sample 1000 outputs 1000 (history cleared).
6. Back-to-back stream of 8 samples with in_empty=0 and out_full=0 -> in_rd_en pulses every 5 cycles; outputs match the C model bit-exactly.

Source files
------------

// File: rtl/preemph_pkg.sv
// preemph_pkg: shared definitions for the transmit pre-emphasis filter and the
// other single-multiplier IIR sections of the audio chain.
//   WORD_WIDTH  - default sample/accumulator width (two's complement)
//   BITS        - quantization fraction bits; QUANT_VAL = 1 << BITS
//   B0/B1/A1_DEFAULT - default quantized taps (1.0, -0.652, 0.0)
//   state_t     - sequencing states of the time-multiplexed filter
//   dequantize  - removes the fraction bits, rounding toward zero
package preemph_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BITS       = 10;
  localparam int QUANT_VAL  = 1 << BITS;

  localparam logic signed [WORD_WIDTH-1:0] B0_DEFAULT = 32'sd1024;
  localparam logic signed [WORD_WIDTH-1:0] B1_DEFAULT = -32'sd668;
  localparam logic signed [WORD_WIDTH-1:0] A1_DEFAULT = 32'sd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_WRITE
  } state_t;

  // A plain arithmetic shift floors; biasing negative values by 2^bits - 1
  // first turns that into truncation toward zero, matching C integer division.
  function automatic logic signed [WORD_WIDTH-1:0] dequantize(
    input logic signed [WORD_WIDTH-1:0] v,
    input int                           bits
  );
    logic signed [WORD_WIDTH-1:0] bias;
    bias = $signed((WORD_WIDTH'(1) << bits) - WORD_WIDTH'(1));
    if (v[WORD_WIDTH-1]) begin
      return (v + bias) >>> bits;
    end
    return v >>> bits;
  endfunction

endpackage

// File: rtl/preemph_iir_mac.sv
// iir_mac: registered accumulator around one signed multiplier, shared by the
// single-multiplier filters of the chain.
// Ports:
//   clock, reset  - system clock, asynchronous active-low reset
//   en            - load the accumulator with sum this cycle
//   clear         - 1: sum = op_a*op_b (start a new sum); 0: sum = acc + op_a*op_b
//   op_a, op_b    - signed operands; the product keeps the low DATA_WIDTH bits
//   sum           - combinational next accumulator value, so the caller can
//                   consume the final term without waiting a cycle
module iir_mac
  import preemph_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] op_a,
  input  logic signed [DATA_WIDTH-1:0] op_b,
  output logic signed [DATA_WIDTH-1:0] sum
);

  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] base;
  logic signed [DATA_WIDTH-1:0] prod;

  // Products and sums wrap at DATA_WIDTH bits, bit-exact with 32-bit int math.
  always_comb begin
    prod = op_a * op_b;
    base = clear ? '0 : acc;
    sum  = base + prod;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of block order.
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/preemph.sv
// preemph: first-order pre-emphasis section between two FIFOs,
//   y[n] = dequantize(B0*x[n] + B1*x[n-1] + A1*y[n-1]),
// computed with one multiplier over three cycles; one sample in flight.
// Ports:
//   clock, reset - system clock, asynchronous active-low reset
//   in_rd_en     - upstream FIFO read strobe (only in S_IDLE)
//   in_empty     - upstream FIFO empty
//   in_dout      - upstream FWFT data, valid while in_empty = 0
//   out_wr_en    - downstream FIFO write strobe
//   out_full     - downstream FIFO full
//   out_din      - downstream FIFO data, zero unless out_wr_en = 1
module preemph
  import preemph_pkg::*;
#(
  parameter int                           DATA_WIDTH = WORD_WIDTH,
  parameter int                           BITS       = preemph_pkg::BITS,
  parameter logic signed [DATA_WIDTH-1:0] B0         = B0_DEFAULT,
  parameter logic signed [DATA_WIDTH-1:0] B1         = B1_DEFAULT,
  parameter logic signed [DATA_WIDTH-1:0] A1         = A1_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din
);

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [DATA_WIDTH-1:0] x1;
  logic signed [DATA_WIDTH-1:0] y1;
  logic signed [DATA_WIDTH-1:0] y_reg;

  logic                         mac_en;
  logic                         mac_clear;
  logic signed [DATA_WIDTH-1:0] mac_a;
  logic signed [DATA_WIDTH-1:0] mac_b;
  logic signed [DATA_WIDTH-1:0] mac_sum;
  logic                         write_fire;

  // Operand schedule for the shared multiplier: one tap per MUL state.
  always_comb begin
    // NOTE: every output gets a default before the case, so states that do
    // not drive an operand cannot infer a latch.
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    case (state)
      S_MUL0: begin
        mac_en    = 1'b1;
        mac_clear = 1'b1;
        mac_a     = B0;
        mac_b     = x_cur;
      end
      S_MUL1: begin
        mac_en = 1'b1;
        mac_a  = B1;
        mac_b  = x1;
      end
      S_MUL2: begin
        mac_en = 1'b1;
        mac_a  = A1;
        mac_b  = y1;
      end
      default: ;
    endcase
  end

  iir_mac #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .en   (mac_en),
    .clear(mac_clear),
    .op_a (mac_a),
    .op_b (mac_b),
    .sum  (mac_sum)
  );

  // FWFT upstream: the read strobe and the data capture share the same cycle.
  // Gated by reset so no word is popped while the block is held in reset.
  assign in_rd_en   = reset && (state == S_IDLE) && !in_empty;
  // Write is combinational on out_full so a release on S_WRITE entry writes at once.
  assign write_fire = (state == S_WRITE) && !out_full;
  assign out_wr_en  = write_fire;
  assign out_din    = write_fire ? y_reg : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // History is cleared too, so a restart begins from silence.
      state <= S_IDLE;
      x_cur <= '0;
      x1    <= '0;
      y1    <= '0;
      y_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!in_empty) begin
            x_cur <= $signed(in_dout);
            state <= S_MUL0;
          end
        end
        S_MUL0: state <= S_MUL1;
        S_MUL1: state <= S_MUL2;
        S_MUL2: begin
          y_reg <= dequantize(mac_sum, BITS);
          state <= S_WRITE;
        end
        S_WRITE: begin
          // History advances only when the sample actually leaves.
          if (!out_full) begin
            x1    <= x_cur;
            y1    <= y_reg;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_preemph.sv
// tb_preemph: directed self-checking bench for preemph. dut_a uses the default
// taps; dut_b uses B1 = 0, A1 = 0.5 to exercise the feedback tap.
module tb_preemph;

  logic        clock;
  logic        reset;

  logic        a_rd, a_empty, a_wr, a_full;
  logic [31:0] a_dout, a_din;
  logic        b_rd, b_empty, b_wr, b_full;
  logic [31:0] b_dout, b_din;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int src[$];
  int rd_cyc[$];
  int got_val[$];
  int got_cyc[$];

  preemph dut_a (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (a_rd),
    .in_empty (a_empty),
    .in_dout  (a_dout),
    .out_wr_en(a_wr),
    .out_full (a_full),
    .out_din  (a_din)
  );

  preemph #(
    .B0(32'sd1024),
    .B1(32'sd0),
    .A1(32'sd512)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (b_rd),
    .in_empty (b_empty),
    .in_dout  (b_dout),
    .out_wr_en(b_wr),
    .out_full (b_full),
    .out_din  (b_din)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference C model with the default taps, 32-bit wrapping int arithmetic.
  function automatic int model_y(input int x, input int xp);
    int acc;
    acc = 1024 * x;
    acc = acc + (-668) * xp;
    if (acc < 0) acc = acc + 1023;
    return acc >>> 10;
  endfunction

  // One clock cycle, entered and left at a negedge. The bench acts as a FWFT
  // FIFO fed from src; outputs are sampled 1ns after the inputs settle.
  task automatic step(input bit use_b, input bit full);
    logic        rd, wr;
    logic [31:0] din;
    logic [31:0] head;
    head = (src.size() != 0) ? 32'(src[0]) : 32'd0;
    if (use_b) begin
      b_empty = (src.size() == 0);
      b_dout  = head;
      b_full  = full;
    end else begin
      a_empty = (src.size() == 0);
      a_dout  = head;
      a_full  = full;
    end
    #1;
    rd  = use_b ? b_rd  : a_rd;
    wr  = use_b ? b_wr  : a_wr;
    din = use_b ? b_din : a_din;
    if (rd) rd_cyc.push_back(cyc);
    if (wr) begin
      got_val.push_back(int'(din));
      got_cyc.push_back(cyc);
    end else begin
      checks++;
      if (din !== 32'd0) begin
        errors++;
        $display("FAIL out_din_idle cyc=%0d got=%0d want=0", cyc, $signed(din));
      end
    end
    @(posedge clock);
    if (rd && src.size() != 0) void'(src.pop_front());
    cyc++;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    a_empty = 1'b1; a_dout = '0; a_full = 1'b0;
    b_empty = 1'b1; b_dout = '0; b_full = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    src.delete();
    rd_cyc.delete();
    got_val.delete();
    got_cyc.delete();
    cyc = 0;
  endtask

  // Compares the logged writes against an expected list.
  task automatic expect_outputs(input string name, input int exp[], input bit chk_lat);
    checks++;
    if (got_val.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d want=%0d", name, got_val.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got_val.size(); i++) begin
      checks++;
      if (got_val[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_val[%0d] got=%0d want=%0d", name, i, got_val[i], exp[i]);
      end
      if (chk_lat && i < rd_cyc.size()) begin
        checks++;
        if (got_cyc[i] - rd_cyc[i] !== 4) begin
          errors++;
          $display("FAIL %s_latency[%0d] got=%0d want=4", name, i, got_cyc[i] - rd_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    a_empty = 1'b0; a_dout = 32'd77; a_full = 1'b0;
    b_empty = 1'b0; b_dout = 32'd77; b_full = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (a_rd !== 1'b0 || b_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en got=%b%b want=00", a_rd, b_rd);
    end
    checks++;
    if (a_wr !== 1'b0 || b_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_en got=%b%b want=00", a_wr, b_wr);
    end
    checks++;
    if (a_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_out_din got=%0d want=0", a_din);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    src = '{1000, 1000};
    repeat (14) step(1'b0, 1'b0);
    expect_outputs("basic", '{1000, 347}, 1'b1);
  endtask

  task automatic test_negative();
    apply_reset();
    src = '{-1000, -1000};
    repeat (14) step(1'b0, 1'b0);
    expect_outputs("negative", '{-1000, -347}, 1'b1);
  endtask

  task automatic test_feedback();
    apply_reset();
    src = '{1000, 0, 0, 0};
    repeat (22) step(1'b1, 1'b0);
    expect_outputs("feedback", '{1000, 500, 250, 125}, 1'b1);
  endtask

  // Downstream full for cycles 4..13 while the first sample sits in S_WRITE.
  task automatic test_backpressure();
    apply_reset();
    src = '{1000, 2000};
    repeat (22) step(1'b0, (cyc >= 4 && cyc < 14));
    expect_outputs("backpressure", '{1000, 1347}, 1'b0);
    checks++;
    if (got_cyc.size() < 2 || got_cyc[0] !== 14 || got_cyc[1] !== 19) begin
      errors++;
      $display("FAIL backpressure_write_cycles got=%p want='{14, 19}", got_cyc);
    end
    checks++;
    if (rd_cyc.size() !== 2 || rd_cyc[1] !== 15) begin
      errors++;
      $display("FAIL backpressure_read_cycles got=%p want='{0, 15}", rd_cyc);
    end
  endtask

  // Reset pulse while the second sample is in S_MUL1.
  task automatic test_reset_midway();
    apply_reset();
    src = '{1000, 500};
    repeat (7) step(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (a_wr !== 1'b0 || a_rd !== 1'b0) begin
      errors++;
      $display("FAIL midreset_strobes got=%b%b want=00", a_rd, a_wr);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (8) step(1'b0, 1'b0);
    checks++;
    if (got_val.size() !== 1) begin
      errors++;
      $display("FAIL midreset_dropped got=%0d writes want=1", got_val.size());
    end
    src.push_back(1000);
    repeat (7) step(1'b0, 1'b0);
    checks++;
    if (got_val.size() !== 2 || got_val[got_val.size()-1] !== 1000) begin
      errors++;
      $display("FAIL midreset_history got=%p want='{1000, 1000}", got_val);
    end
  endtask

  task automatic test_back_to_back();
    int samples[8] = '{100, -200, 3000, -40000, 12345, 3000000, -1, -2097152};
    int exp[8];
    int xp;
    xp = 0;
    foreach (samples[i]) begin
      exp[i] = model_y(samples[i], xp);
      xp = samples[i];
    end
    apply_reset();
    foreach (samples[i]) src.push_back(samples[i]);
    repeat (42) step(1'b0, 1'b0);
    expect_outputs("stream", exp, 1'b1);
    checks++;
    if (rd_cyc.size() !== 8) begin
      errors++;
      $display("FAIL stream_reads got=%0d want=8", rd_cyc.size());
    end
    for (int i = 1; i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] - rd_cyc[i-1] !== 5) begin
        errors++;
        $display("FAIL stream_read_spacing[%0d] got=%0d want=5", i, rd_cyc[i] - rd_cyc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_feedback();
    test_backpressure();
    test_reset_midway();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
